// File: rtl/axis_util_pkg.sv
// axis_util_pkg: shared AXI-Stream helpers and the length-enforcer FSM state
package axis_util_pkg;

    localparam int MAX_KEEP = 128;

    typedef enum logic {PASS, DISCARD} fle_state_e;

    function automatic logic [15:0] popcount(input logic [MAX_KEEP-1:0] keep);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < MAX_KEEP; i++) n = n + 16'(keep[i]);
        return n;
    endfunction

    function automatic logic [MAX_KEEP-1:0] keep_mask(input logic [15:0] n);
        logic [MAX_KEEP-1:0] m;
        for (int i = 0; i < MAX_KEEP; i++) m[i] = i < int'(n);
        return m;
    endfunction

endpackage

// File: rtl/axis_int.sv
// AXIS_int: parameterised AXI-Stream bundle with master/slave views
interface AXIS_int #(
    parameter int DATA_BYTES = 8,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [DATA_BYTES-1:0]   tstrb;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    resetn;

    modport Master (output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
                    input tready, resetn);
    modport Slave  (input tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, resetn,
                    output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry registered skid; in_ready comes straight from a flop
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    logic         m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;

    assign in_ready  = !s_valid_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (out_ready || !m_valid_q) begin
            m_valid_d = s_valid_q || in_valid;
            m_data_d  = s_valid_q ? s_data_q : in_data;
            s_valid_d = 1'b0;
        end else if (in_valid && !s_valid_q) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        m_data_q <= m_data_d;
        s_data_q <= s_data_d;
    end

endmodule

// File: rtl/axis_frame_length_enforcer.sv
// axis_frame_length_enforcer: truncates AXIS frames to MAX_FRAME_BYTES and drops the excess
module axis_frame_length_enforcer #(
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    AXIS_int.Slave               axis_in,
    AXIS_int.Master              axis_out,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] trunc_count,
    output logic                 trunc_pulse
);
    import axis_util_pkg::*;

    localparam int DW  = $bits(axis_in.tdata);
    localparam int KW  = $bits(axis_in.tkeep);
    localparam int IW  = $bits(axis_in.tid);
    localparam int DSW = $bits(axis_in.tdest);
    localparam int UW  = $bits(axis_in.tuser);
    localparam int PW  = DW + KW + 1 + IW + DSW + UW;
    localparam logic [16:0] MAXB = 17'(MAX_FRAME_BYTES);

    if (MAX_FRAME_BYTES < 1 || MAX_FRAME_BYTES > 65535 || KW > MAX_KEEP ||
        $bits(axis_out.tdata) != DW || $bits(axis_out.tkeep) != KW ||
        $bits(axis_out.tid) != IW || $bits(axis_out.tdest) != DSW ||
        $bits(axis_out.tuser) != UW) begin : g_param_check
        $error("axis_frame_length_enforcer: bad MAX_FRAME_BYTES or mismatched stream widths");
    end

    fle_state_e           state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 rdy_q, pulse_q, pulse_d;
    logic [CNT_WIDTH-1:0] frame_q, frame_d, trunc_q, trunc_d;
    logic [15:0]          bytes;
    logic [16:0]          sum;
    logic [MAX_KEEP-1:0]  mask;
    logic                 over, exact, trunc, acc, last_o;
    logic [KW-1:0]        keep_o;
    logic                 sk_valid, sk_ready;
    logic [PW-1:0]        sk_in, sk_out;
    logic                 unused_sigs;

    assign axis_in.tready = rdy_q && (state_q == DISCARD || sk_ready);

    always_comb begin
        bytes    = popcount(MAX_KEEP'(axis_in.tkeep));
        sum      = {1'b0, cnt_q} + {1'b0, bytes};
        over     = sum > MAXB;
        exact    = sum == MAXB && !axis_in.tlast;
        trunc    = over || exact;
        mask     = keep_mask(16'(MAXB - {1'b0, cnt_q}));
        keep_o   = over ? mask[KW-1:0] : axis_in.tkeep;
        last_o   = axis_in.tlast || trunc;
        sk_valid = axis_in.tvalid && rdy_q && state_q == PASS;
        sk_in    = {axis_in.tdata, keep_o, last_o, axis_in.tid, axis_in.tdest, axis_in.tuser};
        acc      = axis_in.tvalid && axis_in.tready;
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        if (acc && state_q == PASS) begin
            pulse_d = trunc;
            cnt_d   = last_o ? '0 : sum[15:0];
            state_d = (trunc && !axis_in.tlast) ? DISCARD : PASS;
        end else if (acc && axis_in.tlast) begin
            state_d = PASS;
        end
        frame_d = (axis_out.tvalid && axis_out.tready && axis_out.tlast && !(&frame_q)) ?
                  frame_q + 1'b1 : frame_q;
        trunc_d = (pulse_q && !(&trunc_q)) ? trunc_q + 1'b1 : trunc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PASS;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            pulse_q <= 1'b0;
            frame_q <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
            pulse_q <= pulse_d;
            frame_q <= frame_d;
            trunc_q <= trunc_d;
        end
    end

    axis_skid_buffer #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (sk_valid),
        .in_data   (sk_in),
        .in_ready  (sk_ready),
        .out_valid (axis_out.tvalid),
        .out_data  (sk_out),
        .out_ready (axis_out.tready)
    );

    assign {axis_out.tdata, axis_out.tkeep, axis_out.tlast,
            axis_out.tid, axis_out.tdest, axis_out.tuser} = sk_out;
    assign axis_out.tstrb = axis_out.tkeep;
    assign frame_count    = frame_q;
    assign trunc_count    = trunc_q;
    assign trunc_pulse    = pulse_q;
    assign unused_sigs    = ^{axis_in.tstrb, axis_in.resetn, axis_out.resetn, mask};

endmodule

// File: tb/tb_axis_frame_length_enforcer.sv
// tb_axis_frame_length_enforcer: scoreboard bench with a frame-level byte-budget model
module tb_axis_frame_length_enforcer;
    localparam int MAXB = 60;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  dest;
        logic [3:0]  user;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    AXIS_int #(.DATA_BYTES(8), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)) ain(), aout(), sin(), sout();

    logic [31:0] frame_count, trunc_count;
    logic        trunc_pulse;
    logic [3:0]  s_frames, s_trunc;
    logic        s_pulse;

    axis_frame_length_enforcer #(.MAX_FRAME_BYTES(MAXB), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .axis_in(ain), .axis_out(aout),
        .frame_count(frame_count), .trunc_count(trunc_count), .trunc_pulse(trunc_pulse));

    axis_frame_length_enforcer #(.MAX_FRAME_BYTES(4), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .axis_in(sin), .axis_out(sout),
        .frame_count(s_frames), .trunc_count(s_trunc), .trunc_pulse(s_pulse));

    beat_t exp_q[$];
    int    vectors = 0, errors = 0;
    int    exp_frames = 0, exp_trunc = 0, pulses = 0;
    bit    rmode = 1'b0;
    logic  rval = 1'b1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        aout.tready = rmode ? 1'($urandom_range(0, 1)) : rval;
    end

    beat_t cur, prev, e;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur = {aout.tdata, aout.tkeep, aout.tlast, aout.tid, aout.tdest, aout.tuser};
            if (trunc_pulse) pulses++;
            if (prev_stall) begin
                check("valid_hold", 80'(aout.tvalid), 80'(1));
                check("payload_hold", 80'(cur), 80'(prev));
            end
            if (aout.tvalid) check("tstrb", 80'(aout.tstrb), 80'(aout.tkeep));
            if (aout.tvalid && aout.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 80'(cur), 80'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 80'(cur), 80'(e));
                end
            end
            prev_stall = aout.tvalid && !aout.tready;
            prev = cur;
        end
    end

    task automatic send(input beat_t b, output int stalls);
        ain.tvalid = 1'b1;
        ain.tdata  = b.data;
        ain.tkeep  = b.keep;
        ain.tstrb  = b.keep;
        ain.tlast  = b.last;
        ain.tid    = b.id;
        ain.tdest  = b.dest;
        ain.tuser  = b.user;
        stalls = 0;
        @(negedge clk);
        while (!ain.tready && stalls < 1000) begin
            stalls++;
            @(negedge clk);
        end
        if (!ain.tready) check("in_ready_timeout", 80'(0), 80'(1));
        @(posedge clk);
        #1;
        ain.tvalid = 1'b0;
    endtask

    task automatic frame(input int nb, input int nbytes, input bit rnd, output int stalls);
        beat_t b;
        int t, bb, st, kb;
        bit done;
        t = 0;
        done = 1'b0;
        stalls = 0;
        for (int i = 0; i < nb; i++) begin
            bb = rnd ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : 8) : nbytes;
            b.data = {$urandom, $urandom};
            b.id   = 4'($urandom);
            b.dest = 4'($urandom);
            b.user = 4'($urandom);
            b.last = (i == nb - 1);
            b.keep = 8'((16'h1 << bb) - 16'h1);
            if (!done) begin
                beat_t x;
                x = b;
                kb = (bb < MAXB - t) ? bb : MAXB - t;
                x.keep = 8'((16'h1 << kb) - 16'h1);
                x.last = b.last || (t + bb >= MAXB);
                if (t + bb > MAXB || (t + bb == MAXB && !b.last)) exp_trunc++;
                exp_q.push_back(x);
                t += bb;
                done = x.last;
            end
            if (rnd && $urandom_range(0, 3) == 0) begin
                ain.tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            send(b, st);
            stalls += st;
        end
        exp_frames++;
    endtask

    task automatic drain_check();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || aout.tvalid) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain", 80'(exp_q.size()), 80'(0));
        check("frame_count", 80'(frame_count), 80'(exp_frames));
        check("trunc_count", 80'(trunc_count), 80'(exp_trunc));
        check("trunc_pulses", 80'(pulses), 80'(exp_trunc));
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        beat_t b;
        ain.tvalid = 0; ain.tdata = 0; ain.tkeep = 0; ain.tstrb = 0; ain.tlast = 0;
        ain.tid = 0; ain.tdest = 0; ain.tuser = 0; ain.resetn = 1; aout.resetn = 1;
        sin.tvalid = 0; sin.tdata = 0; sin.tkeep = 0; sin.tstrb = 0; sin.tlast = 0;
        sin.tid = 0; sin.tdest = 0; sin.tuser = 0; sin.resetn = 1; sout.resetn = 1;
        sout.tready = 1;
        #2 rst = 1'b1;
        #1;
        check("rst_tvalid", 80'(aout.tvalid), 80'(0));
        check("rst_tready", 80'(ain.tready), 80'(0));
        check("rst_frames", 80'(frame_count), 80'(0));
        check("rst_trunc", 80'(trunc_count), 80'(0));
        check("rst_pulse", 80'(trunc_pulse), 80'(0));
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 check("tready_before_edge", 80'(ain.tready), 80'(0));
        @(posedge clk);
        #1 check("tready_after_edge", 80'(ain.tready), 80'(1));

        rmode = 1'b0;
        rval  = 1'b1;
        frame(8, 8, 0, st);  check("stalls_trunc8", 80'(st), 80'(0));
        frame(15, 4, 0, st); check("stalls_exact_last", 80'(st), 80'(0));
        frame(16, 4, 0, st); check("stalls_exact_nolast", 80'(st), 80'(0));
        frame(12, 8, 0, st); check("stalls_discard", 80'(st), 80'(0));
        frame(1, 8, 0, st);  check("stalls_single", 80'(st), 80'(0));
        frame(3, 0, 0, st);  check("stalls_zero", 80'(st), 80'(0));
        frame(2, 8, 0, st);  check("stalls_short", 80'(st), 80'(0));
        drain_check();

        rmode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            frame($urandom_range(1, 12), 0, 1, st);
            if (f % 250 == 249) drain_check();
        end

        rmode = 1'b0;
        rval  = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            b = '{data: {$urandom, $urandom}, keep: 8'hFF, last: 1'b0, id: 4'h1, dest: 4'h2, user: 4'h3};
            send(b, st);
        end
        @(negedge clk) rst = 1'b1;
        #1;
        check("midrst_tvalid", 80'(aout.tvalid), 80'(0));
        check("midrst_tready", 80'(ain.tready), 80'(0));
        check("midrst_frames", 80'(frame_count), 80'(0));
        check("midrst_trunc", 80'(trunc_count), 80'(0));
        exp_q.delete();
        exp_frames = 0;
        exp_trunc = 0;
        pulses = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        rval = 1'b1;
        #1 check("midrst_tready_low", 80'(ain.tready), 80'(0));
        @(posedge clk);
        #1 check("midrst_tready_up", 80'(ain.tready), 80'(1));
        frame(4, 8, 0, st);
        frame(9, 8, 0, st);
        drain_check();

        for (int i = 0; i < 20; i++) begin
            sin.tvalid = 1'b1;
            sin.tkeep  = 8'hFF;
            sin.tlast  = 1'b1;
            sin.tdata  = {$urandom, $urandom};
            @(negedge clk);
            check("sat_in_ready", 80'(sin.tready), 80'(1));
            @(posedge clk);
            #1;
        end
        sin.tvalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_trunc", 80'(s_trunc), 80'(15));
        check("sat_frames", 80'(s_frames), 80'(15));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
